// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer: entry layout, widths and defaults.
package inst_buffer_pkg;

  localparam int unsigned NpcW         = 64;
  localparam int unsigned IrW          = 32;
  localparam int unsigned EntryW       = NpcW + IrW;
  localparam int unsigned DefaultDepth = 8;

  // Alpha-style no-op encoding used by downstream stages for empty slots.
  localparam logic [IrW-1:0] NOOP = 32'h47ff041f;

  typedef struct packed {
    logic [NpcW-1:0] npc;
    logic [IrW-1:0]  ir;
  } ib_entry_t;

endpackage

// File: rtl/inst_buffer.sv
// Two-wide circular instruction buffer between fetch and decode.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NpcW-1:0]            if_NPC_in_1,
  input  logic [NpcW-1:0]            if_NPC_in_2,
  input  logic [IrW-1:0]             if_IR_in_1,
  input  logic [IrW-1:0]             if_IR_in_2,
  input  logic                       if_valid_inst_in_1,
  input  logic                       if_valid_inst_in_2,
  input  logic                       flush,
  input  logic [1:0]                 id_take,
  output logic [NpcW-1:0]            ib_NPC_out_1,
  output logic [NpcW-1:0]            ib_NPC_out_2,
  output logic [IrW-1:0]             ib_IR_out_1,
  output logic [IrW-1:0]             ib_IR_out_2,
  output logic                       ib_valid_out_1,
  output logic                       ib_valid_out_2,
  output logic                       ib_stall_out,
  output logic [$clog2(DEPTH):0]     ib_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  // Pointers wrap naturally because DEPTH is a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p, input logic [1:0] n);
    return p + PtrW'(n);
  endfunction

  ib_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;
  logic [1:0]      n_enq, n_deq, take_clip;
  logic            wr_a_en, wr_b_en;
  logic [PtrW-1:0] wr_a_idx, wr_b_idx, rd_2_idx;
  ib_entry_t       wr_a_data, wr_b_data;

  // Fetch is all-or-nothing two-wide, so stall whenever fewer than two slots are free.
  assign ib_stall_out = (count_q > CntW'(DEPTH - 2));
  assign ib_count     = count_q;

  // Next-state: compact valid slots into tail, clip dequeue to occupancy.
  always_comb begin
    n_enq     = 2'd0;
    wr_a_en   = 1'b0;
    wr_b_en   = 1'b0;
    wr_a_idx  = tail_q;
    wr_b_idx  = ptr_inc(tail_q, 2'd1);
    wr_a_data = if_valid_inst_in_1 ? '{npc: if_NPC_in_1, ir: if_IR_in_1}
                                   : '{npc: if_NPC_in_2, ir: if_IR_in_2};
    wr_b_data = '{npc: if_NPC_in_2, ir: if_IR_in_2};
    if (!ib_stall_out) begin
      wr_a_en = if_valid_inst_in_1 | if_valid_inst_in_2;
      wr_b_en = if_valid_inst_in_1 & if_valid_inst_in_2;
      n_enq   = {1'b0, if_valid_inst_in_1} + {1'b0, if_valid_inst_in_2};
    end
    take_clip = (id_take == 2'd3) ? 2'd2 : id_take;
    if ({{(CntW-2){1'b0}}, take_clip} > count_q) n_deq = count_q[1:0];
    else                                         n_deq = take_clip;
    head_d  = ptr_inc(head_q, n_deq);
    tail_d  = ptr_inc(tail_q, n_enq);
    count_d = count_q + CntW'(n_enq) - CntW'(n_deq);
  end

  // Pointer/count register; reset beats flush beats normal update.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage writes; contents need no reset since outputs are masked by count.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      if (wr_a_en) mem_q[wr_a_idx] <= wr_a_data;
      if (wr_b_en) mem_q[wr_b_idx] <= wr_b_data;
    end
  end

  assign rd_2_idx = ptr_inc(head_q, 2'd1);

  // Read ports driven from registered state only; invalid slots read as zero.
  always_comb begin
    ib_valid_out_1 = (count_q >= CntW'(1));
    ib_valid_out_2 = (count_q >= CntW'(2));
    ib_NPC_out_1   = '0;
    ib_IR_out_1    = '0;
    ib_NPC_out_2   = '0;
    ib_IR_out_2    = '0;
    if (ib_valid_out_1) begin
      ib_NPC_out_1 = mem_q[head_q].npc;
      ib_IR_out_1  = mem_q[head_q].ir;
    end
    if (ib_valid_out_2) begin
      ib_NPC_out_2 = mem_q[rd_2_idx].npc;
      ib_IR_out_2  = mem_q[rd_2_idx].ir;
    end
  end

endmodule

// File: tb/tb_inst_buffer.sv
// Scoreboard bench for inst_buffer (DEPTH = 8).
module tb_inst_buffer;

  localparam int unsigned DEPTH = 8;

  typedef struct {
    logic [63:0] npc;
    logic [31:0] ir;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] if_NPC_in_1, if_NPC_in_2;
  logic [31:0] if_IR_in_1, if_IR_in_2;
  logic        if_valid_inst_in_1, if_valid_inst_in_2;
  logic        flush;
  logic [1:0]  id_take;
  logic [63:0] ib_NPC_out_1, ib_NPC_out_2;
  logic [31:0] ib_IR_out_1, ib_IR_out_2;
  logic        ib_valid_out_1, ib_valid_out_2, ib_stall_out;
  logic [3:0]  ib_count;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  inst_buffer #(.DEPTH(DEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .if_NPC_in_1        (if_NPC_in_1),
    .if_NPC_in_2        (if_NPC_in_2),
    .if_IR_in_1         (if_IR_in_1),
    .if_IR_in_2         (if_IR_in_2),
    .if_valid_inst_in_1 (if_valid_inst_in_1),
    .if_valid_inst_in_2 (if_valid_inst_in_2),
    .flush              (flush),
    .id_take            (id_take),
    .ib_NPC_out_1       (ib_NPC_out_1),
    .ib_NPC_out_2       (ib_NPC_out_2),
    .ib_IR_out_1        (ib_IR_out_1),
    .ib_IR_out_2        (ib_IR_out_2),
    .ib_valid_out_1     (ib_valid_out_1),
    .ib_valid_out_2     (ib_valid_out_2),
    .ib_stall_out       (ib_stall_out),
    .ib_count           (ib_count)
  );

  always #5 clock = ~clock;

  // Drive one cycle of stimulus, advance the reference queue at the edge, sample 1ns later.
  task automatic step(input logic v1, input logic [63:0] n1, input logic [31:0] i1,
                      input logic v2, input logic [63:0] n2, input logic [31:0] i2,
                      input logic [1:0] take, input logic fl, input logic rst);
    int  ndeq;
    bit  stall_m;
    if_valid_inst_in_1 = v1; if_NPC_in_1 = n1; if_IR_in_1 = i1;
    if_valid_inst_in_2 = v2; if_NPC_in_2 = n2; if_IR_in_2 = i2;
    id_take = take; flush = fl; reset = rst;
    @(posedge clock);
    stall_m = (DEPTH - sb.size()) < 2;
    if (rst || fl) begin
      sb.delete();
    end else begin
      ndeq = (int'(take) < sb.size()) ? int'(take) : sb.size();
      repeat (ndeq) void'(sb.pop_front());
      if (!stall_m) begin
        if (v1) sb.push_back('{npc: n1, ir: i1});
        if (v2) sb.push_back('{npc: n2, ir: i2});
      end
    end
    #1;
  endtask

  task automatic idle(input logic [1:0] take);
    step(1'b0, 64'd0, 32'd0, 1'b0, 64'd0, 32'd0, take, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b1, 64'h44, 32'hdeadbeef, 1'b1, 64'h48, 32'hcafef00d, 2'd0, 1'b0, 1'b1);
    n_vec++; if (ib_valid_out_1 !== 1'b0) begin n_err++; $display("FAIL reset_v1 act=%b exp=0", ib_valid_out_1); end
    n_vec++; if (ib_valid_out_2 !== 1'b0) begin n_err++; $display("FAIL reset_v2 act=%b exp=0", ib_valid_out_2); end
    n_vec++; if (ib_count !== 4'd0) begin n_err++; $display("FAIL reset_count act=%0d exp=0", ib_count); end
    n_vec++; if (ib_stall_out !== 1'b0) begin n_err++; $display("FAIL reset_stall act=%b exp=0", ib_stall_out); end
    n_vec++; if ({ib_NPC_out_1, ib_NPC_out_2, ib_IR_out_1, ib_IR_out_2} !== 192'd0) begin
      n_err++; $display("FAIL reset_data act=%h/%h exp=0", ib_NPC_out_1, ib_IR_out_1); end
  endtask

  task automatic test_basic;
    step(1'b1, 64'd4, 32'h11111111, 1'b1, 64'd8, 32'h22222222, 2'd0, 1'b0, 1'b0);
    n_vec++; if ({ib_valid_out_1, ib_valid_out_2} !== 2'b11) begin
      n_err++; $display("FAIL basic_valid act=%b exp=11", {ib_valid_out_1, ib_valid_out_2}); end
    n_vec++; if (ib_count !== 4'd2) begin n_err++; $display("FAIL basic_count act=%0d exp=2", ib_count); end
    n_vec++; if (ib_NPC_out_1 !== sb[0].npc || ib_IR_out_1 !== sb[0].ir) begin
      n_err++; $display("FAIL basic_slot1 act=%h/%h exp=%h/%h", ib_NPC_out_1, ib_IR_out_1, sb[0].npc, sb[0].ir); end
    n_vec++; if (ib_NPC_out_2 !== sb[1].npc || ib_IR_out_2 !== sb[1].ir) begin
      n_err++; $display("FAIL basic_slot2 act=%h/%h exp=%h/%h", ib_NPC_out_2, ib_IR_out_2, sb[1].npc, sb[1].ir); end
    idle(2'd2);
    n_vec++; if (ib_count !== 4'd0) begin n_err++; $display("FAIL basic_drain act=%0d exp=0", ib_count); end
  endtask

  task automatic test_compaction_and_over_request;
    step(1'b0, 64'd0, 32'd0, 1'b1, 64'h10, 32'h33333333, 2'd0, 1'b0, 1'b0);
    n_vec++; if (ib_IR_out_1 !== 32'h33333333 || ib_NPC_out_1 !== 64'h10) begin
      n_err++; $display("FAIL compact_slot1 act=%h/%h exp=10/33333333", ib_NPC_out_1, ib_IR_out_1); end
    n_vec++; if (ib_valid_out_2 !== 1'b0 || ib_IR_out_2 !== 32'd0) begin
      n_err++; $display("FAIL compact_slot2 act=%b/%h exp=0/0", ib_valid_out_2, ib_IR_out_2); end
    n_vec++; if (ib_count !== 4'd1) begin n_err++; $display("FAIL compact_count act=%0d exp=1", ib_count); end
    idle(2'd2);
    n_vec++; if (ib_count !== 4'd0 || ib_valid_out_1 !== 1'b0) begin
      n_err++; $display("FAIL overreq_count act=%0d/%b exp=0/0", ib_count, ib_valid_out_1); end
    // Head must have moved by exactly one: the next pair appears in order.
    step(1'b1, 64'h20, 32'h44444444, 1'b1, 64'h24, 32'h55555555, 2'd0, 1'b0, 1'b0);
    n_vec++; if (ib_IR_out_1 !== sb[0].ir || ib_IR_out_2 !== sb[1].ir) begin
      n_err++; $display("FAIL overreq_head act=%h/%h exp=%h/%h", ib_IR_out_1, ib_IR_out_2, sb[0].ir, sb[1].ir); end
    idle(2'd2);
  endtask

  task automatic test_fill_stall;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 64'h100 + 64'(8*k), 32'hb000_0000 + 32'(2*k),
           1'b1, 64'h104 + 64'(8*k), 32'hb000_0001 + 32'(2*k), 2'd0, 1'b0, 1'b0);
      n_vec++; if (ib_count !== 4'(sb.size())) begin
        n_err++; $display("FAIL fill_count k=%0d act=%0d exp=%0d", k, ib_count, sb.size()); end
      n_vec++; if (ib_stall_out !== (k == 3)) begin
        n_err++; $display("FAIL fill_stall k=%0d act=%b exp=%b", k, ib_stall_out, k == 3); end
    end
    step(1'b1, 64'h900, 32'h99999999, 1'b1, 64'h904, 32'h9999999a, 2'd0, 1'b0, 1'b0);
    n_vec++; if (ib_count !== 4'd8) begin n_err++; $display("FAIL fill_ignored act=%0d exp=8", ib_count); end
    // Dequeue while stalled: inputs still dropped, stall clears afterwards.
    step(1'b1, 64'h910, 32'h9999999b, 1'b1, 64'h914, 32'h9999999c, 2'd2, 1'b0, 1'b0);
    n_vec++; if (ib_count !== 4'd6 || ib_stall_out !== 1'b0) begin
      n_err++; $display("FAIL fill_drain act=%0d/%b exp=6/0", ib_count, ib_stall_out); end
    n_vec++; if (ib_IR_out_1 !== sb[0].ir || ib_NPC_out_2 !== sb[1].npc) begin
      n_err++; $display("FAIL fill_head act=%h/%h exp=%h/%h", ib_IR_out_1, ib_NPC_out_2, sb[0].ir, sb[1].npc); end
    step(1'b1, 64'h920, 32'hc0c0c0c0, 1'b0, 64'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    n_vec++; if (ib_count !== 4'd7 || ib_stall_out !== 1'b1) begin
      n_err++; $display("FAIL stall_at_7 act=%0d/%b exp=7/1", ib_count, ib_stall_out); end
    step(1'b1, 64'h930, 32'hd0d0d0d0, 1'b1, 64'h934, 32'hd0d0d0d1, 2'd2, 1'b0, 1'b0);
    n_vec++; if (ib_count !== 4'd5 || ib_IR_out_1 !== sb[0].ir) begin
      n_err++; $display("FAIL stall_7_drain act=%0d/%h exp=5/%h", ib_count, ib_IR_out_1, sb[0].ir); end
  endtask

  task automatic test_flush_priority;
    step(1'b1, 64'h940, 32'he0e0e0e0, 1'b1, 64'h944, 32'he0e0e0e1, 2'd2, 1'b1, 1'b0);
    n_vec++; if (ib_count !== 4'd0 || ib_stall_out !== 1'b0) begin
      n_err++; $display("FAIL flush_count act=%0d/%b exp=0/0", ib_count, ib_stall_out); end
    n_vec++; if ({ib_valid_out_1, ib_valid_out_2} !== 2'b00 || ib_IR_out_1 !== 32'd0) begin
      n_err++; $display("FAIL flush_valid act=%b/%h exp=00/0", {ib_valid_out_1, ib_valid_out_2}, ib_IR_out_1); end
    step(1'b1, 64'h950, 32'hf0f0f0f0, 1'b1, 64'h954, 32'hf0f0f0f1, 2'd0, 1'b0, 1'b0);
    n_vec++; if (ib_count !== 4'd2 || ib_IR_out_1 !== sb[0].ir || ib_IR_out_2 !== sb[1].ir) begin
      n_err++; $display("FAIL flush_resume act=%0d/%h/%h exp=2/%h/%h", ib_count, ib_IR_out_1, ib_IR_out_2,
                        sb[0].ir, sb[1].ir); end
  endtask

  task automatic test_wrap;
    int k = 0;
    for (int c = 0; c < 13; c++) begin
      n_vec++; if (ib_valid_out_1 !== (sb.size() >= 1) || ib_valid_out_2 !== (sb.size() >= 2)) begin
        n_err++; $display("FAIL wrap_valid c=%0d act=%b%b exp_size=%0d", c, ib_valid_out_1, ib_valid_out_2, sb.size()); end
      if (sb.size() >= 1) begin
        n_vec++; if (ib_NPC_out_1 !== sb[0].npc || ib_IR_out_1 !== sb[0].ir) begin
          n_err++; $display("FAIL wrap_slot1 c=%0d act=%h/%h exp=%h/%h", c, ib_NPC_out_1, ib_IR_out_1, sb[0].npc, sb[0].ir); end
      end
      if (sb.size() >= 2) begin
        n_vec++; if (ib_NPC_out_2 !== sb[1].npc || ib_IR_out_2 !== sb[1].ir) begin
          n_err++; $display("FAIL wrap_slot2 c=%0d act=%h/%h exp=%h/%h", c, ib_NPC_out_2, ib_IR_out_2, sb[1].npc, sb[1].ir); end
      end
      if (k < 20) begin
        step(1'b1, 64'h1000 + 64'(4*k), 32'ha000_0000 + 32'(k),
             1'b1, 64'h1004 + 64'(4*k), 32'ha000_0001 + 32'(k), 2'd2, 1'b0, 1'b0);
        k += 2;
      end else begin
        idle(2'd2);
      end
    end
    n_vec++; if (ib_count !== 4'd0) begin n_err++; $display("FAIL wrap_final act=%0d exp=0", ib_count); end
  endtask

  task automatic test_reset_mid_stream;
    step(1'b1, 64'h2000, 32'h12121212, 1'b1, 64'h2004, 32'h34343434, 2'd0, 1'b0, 1'b0);
    step(1'b1, 64'h2008, 32'h56565656, 1'b1, 64'h200c, 32'h78787878, 2'd1, 1'b1, 1'b1);
    n_vec++; if (ib_count !== 4'd0 || ib_valid_out_1 !== 1'b0 || ib_stall_out !== 1'b0) begin
      n_err++; $display("FAIL midreset act=%0d/%b/%b exp=0/0/0", ib_count, ib_valid_out_1, ib_stall_out); end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; id_take = 2'd0;
    if_valid_inst_in_1 = 1'b0; if_valid_inst_in_2 = 1'b0;
    if_NPC_in_1 = '0; if_NPC_in_2 = '0; if_IR_in_1 = '0; if_IR_in_2 = '0;
    test_reset();
    test_basic();
    test_compaction_and_over_request();
    test_fill_stall();
    test_flush_priority();
    test_wrap();
    test_reset_mid_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
